// File: rtl/camera_frame_capture.sv
// camera_frame_capture
//
// Captures one decimated Y-only frame from a DVP-style camera (YUYV byte order) into
// an external byte-wide RAM. The frame is reduced by keeping one pixel in every
// H_STEP pixels and one line in every V_STEP lines, up to IMG_COLS x IMG_ROWS bytes.
// The block also generates the camera master clock.
//
// Ports
//   i_Clk         system clock, rising edge
//   i_Rst_n       asynchronous active-low reset
//   i_PLK         camera pixel clock (asynchronous to i_Clk)
//   i_VS          camera vsync, high during vertical blanking
//   i_HS          camera href, high while line bytes are valid
//   i_D[7:0]      camera data
//   i_Arm         level request to capture the next full frame
//   o_XLK         camera master clock, period 2*XLK_HALF i_Clk cycles
//   o_Wr_En       one-cycle RAM write strobe
//   o_Wr_Addr     RAM write address
//   o_Wr_Data     RAM write data
//   o_Busy        waiting for a frame start or capturing
//   o_Frame_Done  one-cycle pulse once every stored byte has been written
//   o_Frame_Err   one-cycle pulse when the frame ended before it was complete
module camera_frame_capture #(
  parameter int unsigned IMG_COLS = 96,
  parameter int unsigned IMG_ROWS = 96,
  parameter int unsigned H_STEP   = 6,
  parameter int unsigned V_STEP   = 5,
  parameter int unsigned XLK_HALF = 2
) (
  input  logic        i_Clk,
  input  logic        i_Rst_n,
  input  logic        i_PLK,
  input  logic        i_VS,
  input  logic        i_HS,
  input  logic [7:0]  i_D,
  input  logic        i_Arm,
  output logic        o_XLK,
  output logic        o_Wr_En,
  output logic [14:0] o_Wr_Addr,
  output logic [7:0]  o_Wr_Data,
  output logic        o_Busy,
  output logic        o_Frame_Done,
  output logic        o_Frame_Err
);

  localparam int unsigned Total = IMG_COLS * IMG_ROWS;
  localparam int unsigned XlkW  = (XLK_HALF > 1) ? $clog2(XLK_HALF) : 1;
  localparam int unsigned HphW  = (H_STEP > 1) ? $clog2(H_STEP) : 1;
  localparam int unsigned VphW  = (V_STEP > 1) ? $clog2(V_STEP) : 1;
  localparam int unsigned ColW  = $clog2(IMG_COLS + 1);
  localparam int unsigned RowW  = $clog2(IMG_ROWS + 1);

  localparam logic [14:0]     LastAddr = 15'(Total - 1);
  localparam logic [XlkW-1:0] XlkLast  = XlkW'(XLK_HALF - 1);
  localparam logic [HphW-1:0] HphLast  = HphW'(H_STEP - 1);
  localparam logic [VphW-1:0] VphLast  = VphW'(V_STEP - 1);
  localparam logic [ColW-1:0] ColMax   = ColW'(IMG_COLS);
  localparam logic [RowW-1:0] RowMax   = RowW'(IMG_ROWS);

  typedef enum logic [1:0] {
    StIdle,
    StWaitVs,
    StCapture,
    StDone
  } state_e;

  state_e state_q, state_d;

  // ---------------------------------------------------------------------------
  // Camera master clock
  // ---------------------------------------------------------------------------
  logic [XlkW-1:0] xlk_cnt_q;
  logic            xlk_q;

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      xlk_cnt_q <= '0;
      xlk_q     <= 1'b0;
    end else if (xlk_cnt_q == XlkLast) begin
      xlk_cnt_q <= '0;
      xlk_q     <= ~xlk_q;
    end else begin
      xlk_cnt_q <= xlk_cnt_q + 1'b1;
    end
  end

  assign o_XLK = xlk_q;

  // ---------------------------------------------------------------------------
  // Input synchronizers and edge detection
  // ---------------------------------------------------------------------------
  logic [1:0] plk_sync_q, vs_sync_q, hs_sync_q;
  logic [7:0] d_s1_q, d_s2_q;
  logic       plk_prev_q, vs_prev_q, hs_prev_q;
  // Edge events and the matching data byte, registered together so every
  // decision downstream sees one consistent snapshot of the camera bus.
  logic       byte_evt_q, hs_fall_q, vs_fall_q, vs_rise_q;
  logic [7:0] byte_q;

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      plk_sync_q <= '0;
      vs_sync_q  <= '0;
      hs_sync_q  <= '0;
      d_s1_q     <= '0;
      d_s2_q     <= '0;
      plk_prev_q <= 1'b0;
      vs_prev_q  <= 1'b0;
      hs_prev_q  <= 1'b0;
      byte_evt_q <= 1'b0;
      hs_fall_q  <= 1'b0;
      vs_fall_q  <= 1'b0;
      vs_rise_q  <= 1'b0;
      byte_q     <= '0;
    end else begin
      plk_sync_q <= {plk_sync_q[0], i_PLK};
      vs_sync_q  <= {vs_sync_q[0], i_VS};
      hs_sync_q  <= {hs_sync_q[0], i_HS};
      d_s1_q     <= i_D;
      d_s2_q     <= d_s1_q;
      plk_prev_q <= plk_sync_q[1];
      vs_prev_q  <= vs_sync_q[1];
      hs_prev_q  <= hs_sync_q[1];
      // PLK edges outside href are blanking activity and never count as bytes.
      byte_evt_q <= plk_sync_q[1] & ~plk_prev_q & hs_sync_q[1];
      hs_fall_q  <= hs_prev_q & ~hs_sync_q[1];
      vs_fall_q  <= vs_prev_q & ~vs_sync_q[1];
      vs_rise_q  <= ~vs_prev_q & vs_sync_q[1];
      byte_q     <= d_s2_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Position tracking: byte parity, pixel phase/column, line phase/row
  // ---------------------------------------------------------------------------
  logic [15:0]     byte_cnt_q;
  logic [HphW-1:0] h_phase_q;
  logic [ColW-1:0] col_q;
  logic [VphW-1:0] v_phase_q;
  logic [RowW-1:0] row_q;
  logic [14:0]     addr_q;

  logic wr_hit, last_wr, cap_start, err_d;

  always_comb begin
    // Even byte index is the Y sample; both phases at zero mark a kept pixel/line.
    wr_hit = (state_q == StCapture) && byte_evt_q && !byte_cnt_q[0] &&
             (h_phase_q == '0) && (col_q < ColMax) &&
             (v_phase_q == '0) && (row_q < RowMax);
    last_wr   = wr_hit && (addr_q == LastAddr);
    state_d   = state_q;
    cap_start = 1'b0;
    err_d     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (i_Arm) state_d = StWaitVs;
      end
      StWaitVs: begin
        if (vs_fall_q) begin
          state_d   = StCapture;
          cap_start = 1'b1;
        end
      end
      StCapture: begin
        // The final write wins over a coincident end of frame.
        if (last_wr) begin
          state_d = StDone;
        end else if (vs_rise_q) begin
          state_d = StIdle;
          err_d   = 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      byte_cnt_q <= '0;
      h_phase_q  <= '0;
      col_q      <= '0;
      v_phase_q  <= '0;
      row_q      <= '0;
      addr_q     <= '0;
    end else if (cap_start) begin
      byte_cnt_q <= '0;
      h_phase_q  <= '0;
      col_q      <= '0;
      v_phase_q  <= '0;
      row_q      <= '0;
      addr_q     <= '0;
    end else if (state_q == StCapture) begin
      if (hs_fall_q) begin
        byte_cnt_q <= '0;
        h_phase_q  <= '0;
        col_q      <= '0;
        if (v_phase_q == VphLast) begin
          v_phase_q <= '0;
          // Saturate so lines past the stored area never alias back in.
          if (row_q != RowMax) row_q <= row_q + 1'b1;
        end else begin
          v_phase_q <= v_phase_q + 1'b1;
        end
      end else if (byte_evt_q) begin
        byte_cnt_q <= byte_cnt_q + 1'b1;
        // The odd (chroma) byte closes a pixel, so the pixel position advances here.
        if (byte_cnt_q[0]) begin
          if (h_phase_q == HphLast) begin
            h_phase_q <= '0;
            if (col_q != ColMax) col_q <= col_q + 1'b1;
          end else begin
            h_phase_q <= h_phase_q + 1'b1;
          end
        end
      end
      // Address holds at the last location instead of wrapping.
      if (wr_hit && !last_wr) addr_q <= addr_q + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  logic        wr_en_q;
  logic [14:0] wr_addr_q;
  logic [7:0]  wr_data_q;
  logic        err_q;

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      err_q     <= 1'b0;
    end else begin
      wr_en_q <= wr_hit;
      err_q   <= err_d;
      if (wr_hit) begin
        wr_addr_q <= addr_q;
        wr_data_q <= byte_q;
      end
    end
  end

  assign o_Wr_En      = wr_en_q;
  assign o_Wr_Addr    = wr_addr_q;
  assign o_Wr_Data    = wr_data_q;
  assign o_Frame_Err  = err_q;
  assign o_Frame_Done = (state_q == StDone);
  assign o_Busy       = (state_q == StWaitVs) || (state_q == StCapture);

endmodule

// File: tb/tb_camera_frame_capture.sv
// Bench for camera_frame_capture with a reduced frame geometry so whole frames stay short.
module tb_camera_frame_capture;

  localparam int COLS  = 8;
  localparam int ROWS  = 6;
  localparam int HST   = 3;
  localparam int VST   = 2;
  localparam int XH    = 2;
  localparam int TOTAL = COLS * ROWS;
  // Source position of the last stored byte.
  localparam int CUT_L = (ROWS - 1) * VST;
  localparam int CUT_B = (COLS - 1) * HST * 2;
  localparam int NSCEN = 10;

  logic        i_Clk   = 1'b0;
  logic        i_Rst_n = 1'b0;
  logic        i_PLK   = 1'b0;
  logic        i_VS    = 1'b1;
  logic        i_HS    = 1'b0;
  logic [7:0]  i_D     = 8'h00;
  logic        i_Arm   = 1'b0;
  logic        o_XLK;
  logic        o_Wr_En;
  logic [14:0] o_Wr_Addr;
  logic [7:0]  o_Wr_Data;
  logic        o_Busy;
  logic        o_Frame_Done;
  logic        o_Frame_Err;

  camera_frame_capture #(
    .IMG_COLS (COLS),
    .IMG_ROWS (ROWS),
    .H_STEP   (HST),
    .V_STEP   (VST),
    .XLK_HALF (XH)
  ) u_dut (
    .i_Clk        (i_Clk),
    .i_Rst_n      (i_Rst_n),
    .i_PLK        (i_PLK),
    .i_VS         (i_VS),
    .i_HS         (i_HS),
    .i_D          (i_D),
    .i_Arm        (i_Arm),
    .o_XLK        (o_XLK),
    .o_Wr_En      (o_Wr_En),
    .o_Wr_Addr    (o_Wr_Addr),
    .o_Wr_Data    (o_Wr_Data),
    .o_Busy       (o_Busy),
    .o_Frame_Done (o_Frame_Done),
    .o_Frame_Err  (o_Frame_Err)
  );

  always #5 i_Clk = ~i_Clk;

  // Scenario record: stimulus shape plus hand-derived expected counts.
  typedef struct {
    int nlines;
    int nbytes;
    bit rnd;
    int arm_line;   // -1 arm before frame, -2 no arm, k>=0 arm after line k
    int blank_plk;  // PLK toggles with HS low before each line
    bit vs_last;    // VS rises together with the last stored byte
    int exp_wr;
    int exp_done;
    int exp_err;
  } scen_t;

  scen_t      scen [NSCEN];
  logic [7:0] fr [16][64];
  logic [22:0] cap_q [$];
  logic [22:0] exp_q [$];
  int done_cnt = 0;
  int err_cnt  = 0;
  int checks   = 0;
  int errors   = 0;
  bit armed    = 1'b0;

  // Write/pulse monitor, sampled away from the active edge.
  always @(negedge i_Clk) begin
    if (o_Wr_En) cap_q.push_back({o_Wr_Addr, o_Wr_Data});
    if (o_Frame_Done) done_cnt++;
    if (o_Frame_Err) err_cnt++;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic int outs();
    return int'({o_XLK, o_Wr_En, o_Wr_Addr, o_Wr_Data, o_Busy, o_Frame_Done, o_Frame_Err});
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge i_Clk);
  endtask

  task automatic pulse_arm();
    i_Arm = 1'b1;
    tick(2);
    i_Arm = 1'b0;
    tick(1);
  endtask

  task automatic fill(input bit rnd);
    for (int l = 0; l < 16; l++)
      for (int b = 0; b < 64; b++)
        fr[l][b] = rnd ? 8'($urandom) : 8'((l + b) & 8'hFF);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit vs_hi);
    i_D   = b;
    i_PLK = 1'b1;
    if (vs_hi) i_VS = 1'b1;
    tick(int'($urandom_range(2, 3)));
    i_PLK = 1'b0;
    tick(int'($urandom_range(2, 3)));
  endtask

  task automatic send_line(input int line, input int nbytes, input int blank, input bit vs_last,
                           output bit stop);
    bit hit;
    stop = 1'b0;
    for (int k = 0; k < blank; k++) begin
      i_D   = 8'($urandom);
      i_PLK = 1'b1;
      tick(2);
      i_PLK = 1'b0;
      tick(2);
    end
    i_HS = 1'b1;
    tick(1);
    for (int b = 0; b < nbytes && !stop; b++) begin
      hit = vs_last && (line == CUT_L) && (b == CUT_B);
      send_byte(fr[line][b], hit);
      if (hit) stop = 1'b1;
    end
    i_HS = 1'b0;
    tick(int'($urandom_range(3, 6)));
  endtask

  task automatic run_frame(input scen_t s);
    bit stop;
    stop = 1'b0;
    i_VS = 1'b1;
    tick(3);
    if (s.arm_line == -1) pulse_arm();
    tick(2);
    i_VS = 1'b0;
    tick(4);
    for (int l = 0; l < s.nlines && !stop; l++) begin
      send_line(l, s.nbytes, s.blank_plk, s.vs_last, stop);
      if (l == s.arm_line) pulse_arm();
    end
    i_VS = 1'b1;
    tick(8);
  endtask

  // Reference: walk the stored grid; a cell is written if its source byte was sent.
  // Addresses are the running count of stored bytes.
  task automatic build_exp(input scen_t s);
    int line, b;
    exp_q.delete();
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        line = r * VST;
        b    = c * HST * 2;
        if (line < s.nlines && b < s.nbytes &&
            (!s.vs_last || line < CUT_L || (line == CUT_L && b <= CUT_B)))
          exp_q.push_back({15'(exp_q.size()), fr[line][b]});
      end
    end
  endtask

  initial begin
    int base, d0, e0, nw, mism, first, nhigh, prev, last, hi_len, lo_len, v;
    bit cap, stop;
    scen_t s;

    //            lines bytes rnd arm blank vsl  wr done err
    scen[0] = '{14, 54, 1'b0, -1,  0, 1'b0, 48, 1, 0};  // full frame, pattern data
    scen[1] = '{13, 50, 1'b1, -1,  0, 1'b0, 48, 1, 0};  // full frame, random data
    scen[2] = '{ 5, 54, 1'b1, -1,  0, 1'b0, 24, 0, 1};  // short frame
    scen[3] = '{14, 30, 1'b1, -1,  0, 1'b0, 30, 0, 1};  // narrow lines
    scen[4] = '{14, 54, 1'b1, -2,  0, 1'b0,  0, 0, 0};  // never armed
    scen[5] = '{14, 54, 1'b1,  3,  0, 1'b0,  0, 0, 0};  // late arm mid-frame
    scen[6] = '{14, 54, 1'b1, -2,  0, 1'b0, 48, 1, 0};  // capture from the late arm
    scen[7] = '{ 1, 54, 1'b0, -1, 20, 1'b0,  8, 0, 1};  // PLK activity during blanking
    scen[8] = '{14, 54, 1'b1, -1,  0, 1'b1, 48, 1, 0};  // VS rise with final write
    scen[9] = '{11, 43, 1'b1, -1,  0, 1'b0, 48, 1, 0};  // minimum frame for completion

    // Reset state
    tick(3);
    chk("reset_outputs", outs(), 0);
    i_Rst_n = 1'b1;
    tick(2);
    chk("idle_busy", int'(o_Busy), 0);

    // Master clock shape
    prev = int'(o_XLK); last = -1; hi_len = 0; lo_len = 0;
    for (int k = 1; k <= 24; k++) begin
      tick(1);
      v = int'(o_XLK);
      if (v != prev) begin
        if (last >= 0) begin
          if (prev == 1) hi_len = k - last;
          else lo_len = k - last;
        end
        last = k;
      end
      prev = v;
    end
    chk("xlk_high_cycles", hi_len, XH);
    chk("xlk_low_cycles", lo_len, XH);

    // Latency of a single byte event
    pulse_arm();
    i_VS = 1'b0;
    tick(4);
    chk("waitvs_busy", int'(o_Busy), 1);
    i_HS = 1'b1;
    tick(1);
    base = cap_q.size(); e0 = err_cnt;
    i_D = 8'hA5; i_PLK = 1'b1;
    first = -1; nhigh = 0;
    for (int k = 1; k <= 8; k++) begin
      tick(1);
      if (o_Wr_En) begin
        nhigh++;
        if (first < 0) first = k;
      end
    end
    i_PLK = 1'b0; tick(2);
    i_HS = 1'b0; tick(4);
    i_VS = 1'b1; tick(8);
    chk("latency_first_high", first, 4);
    chk("latency_width", nhigh, 1);
    nw = cap_q.size() - base;
    chk("latency_writes", nw, 1);
    if (nw >= 1) chk("latency_word", int'(cap_q[base]), int'({15'd0, 8'hA5}));
    chk("latency_err", err_cnt - e0, 1);

    // Table-driven frames against the reference model
    for (int i = 0; i < NSCEN; i++) begin
      s = scen[i];
      fill(s.rnd);
      if (s.arm_line == -1) armed = 1'b1;
      cap = armed;
      if (cap) begin
        build_exp(s);
        armed = 1'b0;
      end else begin
        exp_q.delete();
      end
      if (s.arm_line >= 0 && !cap) armed = 1'b1;
      base = cap_q.size(); d0 = done_cnt; e0 = err_cnt;
      run_frame(s);
      nw = cap_q.size() - base;
      chk($sformatf("s%0d_writes", i), nw, s.exp_wr);
      chk($sformatf("s%0d_model_writes", i), nw, exp_q.size());
      mism = 0;
      for (int j = 0; j < nw && j < exp_q.size(); j++)
        if (cap_q[base + j] != exp_q[j]) mism++;
      chk($sformatf("s%0d_content_mismatches", i), mism, 0);
      chk($sformatf("s%0d_done", i), done_cnt - d0, s.exp_done);
      chk($sformatf("s%0d_err", i), err_cnt - e0, s.exp_err);
      chk($sformatf("s%0d_busy", i), int'(o_Busy), int'(armed));
      if (i == 0 && nw >= TOTAL) begin
        chk("addr0_data", int'(cap_q[base][7:0]), 0);
        chk("addr1_data", int'(cap_q[base + 1][7:0]), HST * 2);
        chk("addr_row1_data", int'(cap_q[base + COLS][7:0]), VST);
        chk("last_addr", int'(cap_q[base + TOTAL - 1][22:8]), TOTAL - 1);
      end
    end

    // Reset in the middle of a capture, then no writes without a new arm
    fill(1'b0);
    i_VS = 1'b1; tick(3);
    pulse_arm();
    i_VS = 1'b0; tick(4);
    for (int l = 0; l < 3; l++) send_line(l, 54, 0, 1'b0, stop);
    chk("busy_mid_capture", int'(o_Busy), 1);
    i_Rst_n = 1'b0;
    #1;
    chk("reset_mid_outputs", outs(), 0);
    @(negedge i_Clk);
    i_Rst_n = 1'b1;
    tick(1);
    base = cap_q.size(); d0 = done_cnt; e0 = err_cnt;
    for (int l = 3; l < 14; l++) send_line(l, 54, 0, 1'b0, stop);
    i_VS = 1'b1; tick(8);
    s = '{14, 54, 1'b0, -2, 0, 1'b0, 0, 0, 0};
    run_frame(s);
    chk("post_reset_writes", cap_q.size() - base, 0);
    chk("post_reset_done", done_cnt - d0, 0);
    chk("post_reset_err", err_cnt - e0, 0);
    chk("post_reset_busy", int'(o_Busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/camera_frame_capture.md
CAMERA_FRAME_CAPTURE -- requirements
Module: camera_frame_capture

Interface
REQ-001 The block SHALL expose parameter IMG_COLS, default 96, giving the stored columns per frame.
REQ-002 The block SHALL expose parameter IMG_ROWS, default 96, giving the stored rows per frame.
REQ-003 The block SHALL expose parameter H_STEP, default 6, giving the source pixels per stored column.
REQ-004 The block SHALL expose parameter V_STEP, default 5, giving the source lines per stored row.
REQ-005 The block SHALL expose parameter XLK_HALF, default 2, giving the i_Clk cycles per o_XLK half-period.
REQ-006 Port i_Clk SHALL be an input, 1 bit: the single system clock, rising-edge active.
REQ-007 Port i_Rst_n SHALL be an input, 1 bit: reset, asynchronous and active-low.
REQ-008 Port i_PLK SHALL be an input, 1 bit: camera pixel clock, asynchronous to i_Clk.
REQ-009 Port i_VS SHALL be an input, 1 bit: camera vsync, high during vertical blanking.
REQ-010 Port i_HS SHALL be an input, 1 bit: camera href, high while line bytes are valid.
REQ-011 Port i_D SHALL be an input, 8 bits: camera data, YUYV byte order.
REQ-012 Port i_Arm SHALL be an input, 1 bit: level request to capture the next full frame.
REQ-013 Port o_XLK SHALL be an output, 1 bit: camera master clock.
REQ-014 Port o_Wr_En SHALL be an output, 1 bit: one-cycle RAM write strobe.
REQ-015 Port o_Wr_Addr SHALL be an output, 15 bits: RAM write address.
REQ-016 Port o_Wr_Data SHALL be an output, 8 bits: RAM write data.
REQ-017 Port o_Busy SHALL be an output, 1 bit: high in WAIT_VS and CAPTURE.
REQ-018 Port o_Frame_Done SHALL be an output, 1 bit: one-cycle pulse when all IMG_COLS*IMG_ROWS bytes are written.
REQ-019 Port o_Frame_Err SHALL be an output, 1 bit: one-cycle pulse when a frame ends short.

Function
REQ-020 o_XLK SHALL toggle every XLK_HALF i_Clk cycles in all states, giving a 4-cycle, 50% duty period by default.
REQ-021 i_PLK, i_VS and i_HS SHALL each pass through a 2-flop synchronizer, and i_D SHALL be delayed 2 stages to stay aligned with them.
REQ-022 A byte event SHALL be one rising edge of synchronized PLK while synchronized HS is high; PLK edges while HS is low SHALL be ignored.
REQ-023 The FSM SHALL have states IDLE, WAIT_VS, CAPTURE and DONE, with IDLE as the reset state.
REQ-024 IDLE SHALL go to WAIT_VS when i_Arm=1; i_Arm SHALL be ignored in every other state.
REQ-025 WAIT_VS SHALL go to CAPTURE on a synchronized VS falling edge, and SHALL NOT enter CAPTURE if VS is already low on entry.
REQ-026 On CAPTURE entry, the byte, pixel, line and phase counters and the write address SHALL be cleared to 0.
REQ-027 The byte-in-line counter SHALL increment on each byte event; the pixel index SHALL equal byte count >> 1.
REQ-028 A synchronized HS falling edge SHALL clear the byte counter and increment the line counter.
REQ-029 A write SHALL occur when the byte index is even (Y), pixel mod H_STEP = 0, pixel/H_STEP < IMG_COLS, line mod V_STEP = 0 and line/V_STEP < IMG_ROWS.
REQ-030 Modulo tests SHALL use wrapping phase counters; no dividers SHALL be used.
REQ-031 On a write, o_Wr_Data SHALL be the aligned byte, o_Wr_Addr SHALL be the current address, and the address SHALL then increment.
REQ-032 o_Wr_En SHALL assert exactly 3 i_Clk cycles after the first edge that samples i_PLK high.
REQ-033 The write of address IMG_COLS*IMG_ROWS-1 (9215) SHALL move the FSM to DONE, and the address SHALL NOT wrap.
REQ-034 DONE SHALL pulse o_Frame_Done for one cycle and return to IDLE the next cycle.
REQ-035 A synchronized VS rising edge in CAPTURE before address 9215 is written SHALL pulse o_Frame_Err, return the FSM to IDLE and produce no o_Frame_Done.
REQ-036 If a VS rising edge and the final write occur in the same cycle, the final write SHALL take precedence: write, Done, no Err.
REQ-037 Lines beyond IMG_ROWS*V_STEP and pixels beyond IMG_COLS*H_STEP SHALL produce no writes.

Reset
REQ-038 When i_Rst_n=0, the block SHALL immediately set the FSM to IDLE, clear all counters and synchronizers, and drive all outputs to 0, including o_XLK.
REQ-039 After reset deassertion, no write SHALL occur before a new i_Arm followed by a VS falling edge.

Verification
REQ-040 Reset: assert i_Rst_n=0 mid-CAPTURE -> all outputs 0 the same cycle; after release and 1000 frame bytes with no i_Arm -> zero writes.
REQ-041 Full frame: i_Arm=1, 480 lines x 1280 bytes with byte value = (line+byte)&0xFF -> 9216 writes, addr 0..9215 ascending, addr0=0x00, addr1=0x0C, addr96=0x05; one o_Frame_Done; o_Busy ends low.
REQ-042 Short frame: VS rises after 100 lines -> 1920 writes, one o_Frame_Err, no o_Frame_Done, FSM in IDLE.
REQ-043 Late arm: i_Arm asserted mid-frame while VS is low -> no writes until the next VS fall, then a full 9216-byte capture.
REQ-044 Clock and blanking: o_XLK measured -> period 4 cycles, high 2 cycles; PLK toggling with HS=0 -> no writes, byte counter unchanged.
REQ-045 Latency: single byte event -> o_Wr_En high exactly 3 cycles after i_PLK is first sampled high, for exactly 1 cycle.
